// File: rtl/temporizador_maquina.sv
// -----------------------------------------------------------------------------
// temporizador_maquina
//
// Shared timer scheduler for the beverage-machine state machine. A single
// prescaler and a single seconds counter serve seven per-state timer requests.
// Raising a request level starts a countdown of that request's duration. The
// matching done bit is the state machine's T* expiry input.
//
// Ports
//   clock      in   1  system clock, all logic on posedge
//   reset_n    in   1  asynchronous active-low reset
//   req        in   7  request levels {sensor,errMoeda,entre,aqueci,pressu,
//                      moeda,bebida}
//   done       out  7  expiry level, one-hot or zero; bit i answers req[i]
//   remaining  out  4  seconds left for the active request, 0 when idle or
//                      expired
//   busy       out  1  high while a countdown is running
//   multi_req  out  1  high the cycle after more than one req bit was sampled
//
// Parameters
//   TICK_DIV   clock cycles per one-second tick (>= 2)
//   DUR_LONG   seconds for bebida, moeda, aqueci (1..15)
//   DUR_SHORT  seconds for pressu, entre (1..15)
//   DUR_ERR    seconds for errMoeda, sensor (1..15)
// -----------------------------------------------------------------------------
module temporizador_maquina #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [3:0]  DUR_LONG  = 4'd10,
  parameter logic [3:0]  DUR_SHORT = 4'd2,
  parameter logic [3:0]  DUR_ERR   = 4'd6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] req,
  output logic [6:0] done,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       multi_req
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  // Index of the lowest set request bit; lower index has priority.
  function automatic logic [2:0] lowest_idx(input logic [6:0] r);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (r[i]) begin
        res = 3'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // True when two or more request bits are high at once.
  function automatic logic more_than_one(input logic [6:0] r);
    return ((r & (r - 7'd1)) != 7'd0);
  endfunction

  // Countdown length in seconds for each request slot.
  function automatic logic [3:0] dur_of(input logic [2:0] i);
    logic [3:0] d;
    case (i)
      3'd0:    d = DUR_LONG;
      3'd1:    d = DUR_LONG;
      3'd2:    d = DUR_SHORT;
      3'd3:    d = DUR_LONG;
      3'd4:    d = DUR_SHORT;
      3'd5:    d = DUR_ERR;
      3'd6:    d = DUR_ERR;
      default: d = DUR_LONG;
    endcase
    return d;
  endfunction

  // One-hot done pattern for a request slot.
  function automatic logic [6:0] onehot_of(input logic [2:0] i);
    return 7'd1 << i;
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    remaining_q, remaining_d;
  logic [6:0]    done_q, done_d;
  logic          busy_q, busy_d;
  logic          multi_req_q, multi_req_d;

  logic          any_req_s;
  logic [2:0]    load_idx_s;

  assign any_req_s  = |req;
  assign load_idx_s = lowest_idx(req);

  // Next-state and next-output computation for the scheduler.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    done_d      = done_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          idx_d       = load_idx_s;
          remaining_d = dur_of(load_idx_s);
          presc_d     = '0;
          state_d     = ST_COUNT;
          done_d      = 7'd0;
        end else begin
          state_d     = ST_IDLE;
          remaining_d = 4'd0;
        end
      end

      ST_COUNT: begin
        if (!req[idx_q]) begin
          // Winner dropped: abort without signalling done, then either hand
          // off to the next requester or return to idle.
          done_d  = 7'd0;
          presc_d = '0;
          if (any_req_s) begin
            idx_d       = load_idx_s;
            remaining_d = dur_of(load_idx_s);
            state_d     = ST_COUNT;
          end else begin
            remaining_d = 4'd0;
            state_d     = ST_IDLE;
          end
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (remaining_q <= 4'd1) begin
            // Last second elapsed; saturate at zero and raise expiry.
            remaining_d = 4'd0;
            state_d     = ST_EXPIRED;
            done_d      = onehot_of(idx_q);
          end else begin
            remaining_d = remaining_q - 4'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      ST_EXPIRED: begin
        if (!req[idx_q]) begin
          done_d  = 7'd0;
          presc_d = '0;
          if (any_req_s) begin
            idx_d       = load_idx_s;
            remaining_d = dur_of(load_idx_s);
            state_d     = ST_COUNT;
          end else begin
            remaining_d = 4'd0;
            state_d     = ST_IDLE;
          end
        end else begin
          // Hold expiry while the requester still asserts its level.
          done_d = onehot_of(idx_q);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        idx_d       = 3'd0;
        presc_d     = '0;
        remaining_d = 4'd0;
        done_d      = 7'd0;
      end
    endcase

    busy_d      = (state_d == ST_COUNT);
    multi_req_d = more_than_one(req);
  end

  // State and registered outputs, cleared immediately by reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      presc_q     <= '0;
      remaining_q <= 4'd0;
      done_q      <= 7'd0;
      busy_q      <= 1'b0;
      multi_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      multi_req_q <= multi_req_d;
    end
  end

  assign done      = done_q;
  assign remaining = remaining_q;
  assign busy      = busy_q;
  assign multi_req = multi_req_q;

endmodule

// File: tb/tb_temporizador_maquina.sv
// Directed bench for temporizador_maquina with TICK_DIV=4 and default
// durations (long=10, short=2, err=6 seconds).
module tb_temporizador_maquina;

  logic       clock;
  logic       reset_n;
  logic [6:0] req;
  logic [6:0] done;
  logic [3:0] remaining;
  logic       busy;
  logic       multi_req;

  int total;
  int bad;

  temporizador_maquina #(
    .TICK_DIV (4),
    .DUR_LONG (4'd10),
    .DUR_SHORT(4'd2),
    .DUR_ERR  (4'd6)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .done     (done),
    .remaining(remaining),
    .busy     (busy),
    .multi_req(multi_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 7'd0;
    tick();
    tick();
    total++; if (done !== 7'd0)      begin bad++; $display("FAIL reset_done: got %b want %b", done, 7'd0); end
    total++; if (remaining !== 4'd0) begin bad++; $display("FAIL reset_rem: got %0d want 0", remaining); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (multi_req !== 1'b0) begin bad++; $display("FAIL reset_multi: got %b want 0", multi_req); end
    reset_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_short();
    req = 7'b0000100;
    tick(); // edge k
    total++; if (remaining !== 4'd2) begin bad++; $display("FAIL short_rem_k: got %0d want 2", remaining); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL short_busy_k: got %b want 1", busy); end
    for (int i = 1; i < 4; i++) tick();
    total++; if (remaining !== 4'd2) begin bad++; $display("FAIL short_rem_k3: got %0d want 2", remaining); end
    tick(); // k+4
    total++; if (remaining !== 4'd1) begin bad++; $display("FAIL short_rem_k4: got %0d want 1", remaining); end
    for (int i = 5; i < 8; i++) tick();
    total++; if (done !== 7'd0)      begin bad++; $display("FAIL short_done_k7: got %b want %b", done, 7'd0); end
    tick(); // k+8
    total++; if (remaining !== 4'd0) begin bad++; $display("FAIL short_rem_k8: got %0d want 0", remaining); end
    total++; if (done !== 7'b0000100) begin bad++; $display("FAIL short_done_k8: got %b want %b", done, 7'b0000100); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL short_busy_k8: got %b want 0", busy); end
    req = 7'd0;
    tick();
    total++; if (done !== 7'd0)      begin bad++; $display("FAIL short_done_clr: got %b want %b", done, 7'd0); end
  endtask

  task automatic test_swap();
    int early;
    early = 0;
    req = 7'b0000001;
    tick(); // k
    total++; if (remaining !== 4'd10) begin bad++; $display("FAIL swap_rem_k: got %0d want 10", remaining); end
    for (int i = 1; i < 20; i++) begin
      tick();
      if (done !== 7'd0) early++;
    end
    total++; if (remaining !== 4'd6) begin bad++; $display("FAIL swap_rem_k19: got %0d want 6", remaining); end
    req = 7'b1000000;
    tick(); // k+20
    total++; if (remaining !== 4'd6) begin bad++; $display("FAIL swap_rem_k20: got %0d want 6", remaining); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL swap_busy_k20: got %b want 1", busy); end
    for (int i = 1; i < 24; i++) begin
      tick();
      if (done !== 7'd0) early++;
    end
    total++; if (early !== 0)        begin bad++; $display("FAIL swap_no_early_done: got %0d want 0", early); end
    tick(); // k+44
    total++; if (done !== 7'b1000000) begin bad++; $display("FAIL swap_done6: got %b want %b", done, 7'b1000000); end
    req = 7'd0;
    tick();
  endtask

  task automatic test_multi();
    req = 7'b0001100;
    tick(); // k
    total++; if (remaining !== 4'd2) begin bad++; $display("FAIL multi_rem_k: got %0d want 2", remaining); end
    tick(); // k+1
    total++; if (multi_req !== 1'b1) begin bad++; $display("FAIL multi_flag: got %b want 1", multi_req); end
    for (int i = 2; i < 9; i++) tick(); // through k+8
    total++; if (done !== 7'b0000100) begin bad++; $display("FAIL multi_done2: got %b want %b", done, 7'b0000100); end
    req = 7'd0;
    tick();
    total++; if (multi_req !== 1'b0) begin bad++; $display("FAIL multi_flag_clr: got %b want 0", multi_req); end
    total++; if (done !== 7'd0)      begin bad++; $display("FAIL multi_done_clr: got %b want %b", done, 7'd0); end
  endtask

  task automatic test_hold();
    int drops;
    drops = 0;
    req = 7'b0100000;
    tick(); // k
    for (int i = 1; i < 24; i++) tick();
    total++; if (done !== 7'd0)       begin bad++; $display("FAIL hold_done_k23: got %b want %b", done, 7'd0); end
    tick(); // k+24
    total++; if (done !== 7'b0100000) begin bad++; $display("FAIL hold_done_k24: got %b want %b", done, 7'b0100000); end
    for (int i = 25; i < 100; i++) begin
      tick();
      if (done !== 7'b0100000) drops++;
    end
    total++; if (drops !== 0)         begin bad++; $display("FAIL hold_done_held: got %0d drops want 0", drops); end
    req = 7'd0;
    tick();
    total++; if (done !== 7'd0)       begin bad++; $display("FAIL hold_done_clr: got %b want %b", done, 7'd0); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL hold_busy: got %b want 0", busy); end
    tick();
    total++; if (remaining !== 4'd0)  begin bad++; $display("FAIL hold_rem_idle: got %0d want 0", remaining); end
  endtask

  task automatic test_reset_mid();
    req = 7'b0001000;
    tick(); // k
    for (int i = 1; i < 10; i++) tick(); // k+9
    total++; if (remaining !== 4'd8) begin bad++; $display("FAIL rst_rem_before: got %0d want 8", remaining); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (remaining !== 4'd0) begin bad++; $display("FAIL rst_rem_async: got %0d want 0", remaining); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy_async: got %b want 0", busy); end
    total++; if (done !== 7'd0)      begin bad++; $display("FAIL rst_done_async: got %b want %b", done, 7'd0); end
    tick();
    reset_n = 1'b1;
    tick(); // k'
    total++; if (remaining !== 4'd10) begin bad++; $display("FAIL rst_reload: got %0d want 10", remaining); end
    for (int i = 1; i < 40; i++) tick();
    total++; if (done !== 7'd0)      begin bad++; $display("FAIL rst_done_k39: got %b want %b", done, 7'd0); end
    tick(); // k'+40
    total++; if (done !== 7'b0001000) begin bad++; $display("FAIL rst_done_k40: got %b want %b", done, 7'b0001000); end
    req = 7'd0;
    tick();
  endtask

  task automatic test_back_to_back();
    req = 7'b0010000;
    tick(); // k
    for (int i = 1; i < 9; i++) tick();
    total++; if (done !== 7'b0010000) begin bad++; $display("FAIL b2b_done4: got %b want %b", done, 7'b0010000); end
    req = 7'b0000001;
    tick();
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
    total++; if (remaining !== 4'd10) begin bad++; $display("FAIL b2b_rem: got %0d want 10", remaining); end
    total++; if (done !== 7'd0)       begin bad++; $display("FAIL b2b_done_clr: got %b want %b", done, 7'd0); end
    req = 7'd0;
    tick();
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL b2b_abort_idle: got %b want 0", busy); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    req     = 7'd0;
    test_reset();
    test_short();
    test_swap();
    test_multi();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
